spi_master_multi: RTL and testbench

//  Generic parametrised SPI master: the successor to the single-ADC, fixed-mode SPI engine.

---
 rtl/spi_master_multi.sv | 201 ++++++++++++++++++++
 tb/tb_spi_master_multi.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_multi.sv
// spi_master_multi: parametrised SPI master, WIDTH-bit MSB-first words, per-transfer CPOL/CPHA, NUM_CS selects.
// Optional build macro SPI_MASTER_MULTI_LOOPBACK_EN adds _i_loopback (sample internal mosi instead of the pin).
module spi_master_multi #(
  parameter int WIDTH     = 16,
  parameter int DIV       = 50,
  parameter int NUM_CS    = 4,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter bit IDLE_CPOL = 1'b1,
  localparam int CSW      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              _i_clk,
  input  logic              _i_rst_n,
  input  logic              _i_start,
  output logic              _o_ready,
  input  logic [WIDTH-1:0]  _i_tx_data,
  input  logic              _i_cpol,
  input  logic              _i_cpha,
  input  logic [CSW-1:0]    _i_cs_sel,
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
  input  logic              _i_loopback,
`endif
  input  logic              _i_miso_unsync,
  output logic              _o_sclk,
  output logic              _o_mosi,
  output logic [NUM_CS-1:0] _o_cs_n,
  output logic              _o_busy,
  output logic [WIDTH-1:0]  _o_rx_data,
  output logic              _o_rx_valid
);

  localparam int CNT_W  = $clog2(DIV + CS_SETUP + CS_HOLD + 2);
  localparam int HALF_W = $clog2(2 * WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic [WIDTH-1:0]    tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0]    rx_sr_q, rx_sr_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic [WIDTH-1:0]    rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                miso_s1, miso_s2;
  logic                sample;
  logic                half_end;
  logic                last_half;
  logic                shift_mosi;
  logic                take_sample;

`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
  logic                lb_q, lb_d;
  assign sample = lb_q ? mosi_q : miso_s2;
`else
  assign sample = miso_s2;
`endif

  assign half_end  = (cnt_q == CNT_W'(DIV - 1));
  assign last_half = (half_q == HALF_W'(2 * WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    shift_mosi  = 1'b0;
    take_sample = 1'b0;
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
    lb_d        = lb_q;
`endif
    case (state_q)
      IDLE: begin
        if (_i_start) begin
          state_d = SETUP;
          cnt_d   = '0;
          cpol_d  = _i_cpol;
          cpha_d  = _i_cpha;
          tx_sr_d = _i_tx_data;
          mosi_d  = _i_tx_data[WIDTH-1];
          sclk_d  = _i_cpol;
          for (int unsigned i = 0; i < NUM_CS; i++) begin
            cs_n_d[i] = (_i_cs_sel != CSW'(i));
          end
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
          lb_d    = _i_loopback;
`endif
        end
      end
      SETUP: begin
        // CS_SETUP+1 cycles here: the accept cycle plus CS_SETUP setup clocks
        if (cnt_q == CNT_W'(CS_SETUP)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          half_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (half_end) begin
          cnt_d  = '0;
          sclk_d = half_q[0] ? cpol_q : ~cpol_q;
          if (!half_q[0]) begin
            take_sample = !cpha_q;
            shift_mosi  = cpha_q && (half_q != '0);
          end else begin
            take_sample = cpha_q;
            shift_mosi  = !cpha_q && !last_half;
          end
          if (last_half) begin
            state_d = HOLD;
          end else begin
            half_d = half_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (shift_mosi) begin
          mosi_d  = tx_sr_q[WIDTH-2];
          tx_sr_d = tx_sr_q << 1;
        end
        if (take_sample) begin
          rx_sr_d = {rx_sr_q[WIDTH-2:0], sample};
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          state_d    = IDLE;
          cs_n_d     = '1;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge _i_clk) begin
    if (!_i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      half_q     <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      sclk_q     <= IDLE_CPOL;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_s1    <= 1'b0;
      miso_s2    <= 1'b0;
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
      lb_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_s1    <= _i_miso_unsync;
      miso_s2    <= miso_s1;
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
      lb_q       <= lb_d;
`endif
    end
  end

  assign _o_ready    = (state_q == IDLE);
  assign _o_busy     = (state_q != IDLE);
  assign _o_sclk     = sclk_q;
  assign _o_mosi     = mosi_q;
  assign _o_cs_n     = cs_n_q;
  assign _o_rx_data  = rx_data_q;
  assign _o_rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Scoreboard bench for spi_master_multi: behavioural SPI slave, edge timing monitor, queue of expected words.
module tb_spi_master_multi;
  localparam int WIDTH    = 16;
  localparam int DIV      = 50;
  localparam int NUM_CS   = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int LAT      = 1 + CS_SETUP + 2 * WIDTH * DIV + CS_HOLD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic        miso = 1'b0;
  logic [1:0]  cs_sel = '0;
  logic [15:0] tx_data = '0;
  logic        ready, sclk, mosi, busy, rx_valid;
  logic [3:0]  cs_n;
  logic [15:0] rx_data;
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
  logic        loopback = 1'b0;
`endif

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [15:0] tx;
    logic [15:0] slv;
    logic [15:0] rx;
    logic [3:0]  cs;
    logic        cpol;
    logic        cpha;
    int unsigned t0;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] slave_word = '0;

  spi_master_multi #(
    .WIDTH(WIDTH), .DIV(DIV), .NUM_CS(NUM_CS),
    .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .IDLE_CPOL(1'b1)
  ) dut (
    ._i_clk(clk),
    ._i_rst_n(rst_n),
    ._i_start(start),
    ._o_ready(ready),
    ._i_tx_data(tx_data),
    ._i_cpol(cpol),
    ._i_cpha(cpha),
    ._i_cs_sel(cs_sel),
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
    ._i_loopback(loopback),
`endif
    ._i_miso_unsync(miso),
    ._o_sclk(sclk),
    ._o_mosi(mosi),
    ._o_cs_n(cs_n),
    ._o_busy(busy),
    ._o_rx_data(rx_data),
    ._o_rx_valid(rx_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp_v, cyc);
    end
  endtask

  // Slave model, edge monitor and scoreboard, all sampled on the falling clock edge.
  logic        prev_busy = 1'b0;
  logic        prev_sclk = 1'b1;
  logic        spacing_bad = 1'b0;
  logic [15:0] slave_rx = '0;
  logic [15:0] cur_word;
  int unsigned edges = 0, sbit = 0, lead_cnt = 0;
  int unsigned cs_high_run = 0, last_gap = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (busy && !prev_busy && sb.size() > 0) begin
        edges = 0; sbit = 0; lead_cnt = 0; spacing_bad = 1'b0; slave_rx = '0;
        cur_word = sb[0].slv;
        miso = cur_word[15];
        check_eq("cs_n_sel", {28'd0, cs_n}, {28'd0, sb[0].cs});
      end else if (busy && sclk != prev_sclk && sb.size() > 0) begin
        if (cyc != sb[0].t0 + 1 + CS_SETUP + (edges + 1) * DIV) spacing_bad = 1'b1;
        if (sclk != sb[0].cpol) begin
          if (!sb[0].cpha) slave_rx = {slave_rx[14:0], mosi};
          else if (lead_cnt > 0) sbit++;
          lead_cnt++;
        end else begin
          if (sb[0].cpha) slave_rx = {slave_rx[14:0], mosi};
          else sbit++;
        end
        cur_word = sb[0].slv;
        if (sbit < 16) miso = cur_word[15 - sbit];
        edges++;
      end
      if (rx_valid) begin
        if (sb.size() == 0) begin
          check_eq("rx_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("rx_data", {16'd0, rx_data}, {16'd0, e.rx});
          check_eq("latency", cyc - e.t0, LAT);
          check_eq("mosi_bits", {16'd0, slave_rx}, {16'd0, e.tx});
          check_eq("sclk_edges", edges, 2 * WIDTH);
          check_eq("edge_spacing", {31'd0, spacing_bad}, 32'd0);
          check_eq("sclk_idle", {31'd0, sclk}, {31'd0, e.cpol});
          check_eq("cs_release", {28'd0, cs_n}, 32'hF);
        end
      end
      if (start && ready) begin
        e.tx = tx_data; e.slv = slave_word; e.rx = slave_word;
        e.cs = 4'hF; e.cs[cs_sel] = 1'b0;
        e.cpol = cpol; e.cpha = cpha; e.t0 = cyc + 1;
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
        if (loopback) e.rx = tx_data;
`endif
        sb.push_back(e);
      end
      if (cs_n == 4'hF) cs_high_run++;
      else begin
        if (cs_high_run > 0) last_gap = cs_high_run;
        cs_high_run = 0;
      end
    end
    prev_busy = busy;
    prev_sclk = sclk;
  end

  task automatic send(input logic [15:0] tx, input logic [15:0] slv, input logic pol,
                      input logic pha, input logic [1:0] sel, input bit hold_start);
    int unsigned n;
    tx_data = tx; slave_word = slv; cpol = pol; cpha = pha; cs_sel = sel; start = 1'b1;
    n = 0;
    while (!ready && n < 2 * LAT) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("accept_wait", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    while ((sb.size() != 0 || !ready) && n < 2 * LAT) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("done_wait", {31'd0, (sb.size() == 0)}, 32'd1);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_sclk", {31'd0, sclk}, 32'd1);
    check_eq("rst_mosi", {31'd0, mosi}, 32'd0);
    check_eq("rst_cs_n", {28'd0, cs_n}, 32'hF);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ready", {31'd0, ready}, 32'd1);
    check_eq("rst_rx_data", {16'd0, rx_data}, 32'd0);
    check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    repeat (2000) @(posedge clk);
    #1;
    check_eq("idle_sclk", {31'd0, sclk}, 32'd1);
    check_eq("idle_cs_n", {28'd0, cs_n}, 32'hF);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    check_eq("idle_ready", {31'd0, ready}, 32'd1);

    // mode 3, with a start pulse mid-transfer that must be ignored
    send(16'hB2A5, 16'h9D0F, 1'b1, 1'b1, 2'd2, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    tx_data = 16'hFFFF; cpol = 1'b0; cpha = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    send(16'hB2A5, 16'h9D0F, 1'b0, 1'b0, 2'd0, 1'b0);
    wait_done();
    send(16'hB2A5, 16'h9D0F, 1'b0, 1'b1, 2'd1, 1'b0);
    wait_done();
    send(16'hB2A5, 16'h9D0F, 1'b1, 1'b0, 2'd3, 1'b0);
    wait_done();

    send(16'h0001, 16'h6C31, 1'b0, 1'b0, 2'd1, 1'b1);
    send(16'h8000, 16'h1E87, 1'b0, 1'b0, 2'd1, 1'b0);
    wait_done();
    check_eq("b2b_cs_gap", last_gap, 32'd1);

    // reset in the middle of SHIFT (half-period index 10, sclk at CPOL=0)
    send(16'hA5C3, 16'h3C3C, 1'b0, 1'b0, 2'd1, 1'b0);
    repeat (CS_SETUP + 10 * DIV + DIV / 2) @(posedge clk);
    #1;
    check_eq("pre_rst_sclk", {31'd0, sclk}, 32'd0);
    check_eq("pre_rst_cs_n", {28'd0, cs_n}, 32'hD);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_cs_n", {28'd0, cs_n}, 32'hF);
    check_eq("abort_sclk", {31'd0, sclk}, 32'd1);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    send(16'h5A5A, 16'hC0DE, 1'b0, 1'b0, 2'd0, 1'b0);
    wait_done();

`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
    loopback = 1'b1;
    send(16'hC3E1, 16'h0000, 1'b1, 1'b1, 2'd0, 1'b0);
    loopback = 1'b0;
    wait_done();
`endif

    repeat (10) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
